// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game datapath.
// Colour and sequencer-state encodings, segment limits, one-hot helper.
package simon_pkg;

  typedef enum logic [1:0] {
    C_RED,
    C_GREEN,
    C_BLUE,
    C_YELLOW
  } colour_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ON,
    GAP,
    DONE
  } seq_state_t;

  localparam int MAX_SEGMENTS = 33;
  localparam logic [2:0] SPEED_MAX = 3'd4;

  function automatic logic [3:0] onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/seq_speed_lut.sv
// Round length to timer speed code, saturating at SPEED_MAX.
// Ports: round_len (in), speed (out, 0..4).
module seq_speed_lut
  import simon_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int RAMP  = 5
) (
  input  logic [IDX_W-1:0] round_len,
  output logic [2:0]       speed
);

  logic [IDX_W-1:0] steps;

  assign steps = round_len / IDX_W'(RAMP);

  assign speed = (steps > IDX_W'(SPEED_MAX)) ?
                 SPEED_MAX : steps[2:0];

endmodule

// File: rtl/flash_sequencer.sv
// Plays the stored colour sequence back on the LEDs each round.
// Ports: clk, reset(n), start, abort, round_len, colour_in, pulse
//   -> seg_idx, load_speed, speed, led_o, busy, done.
module flash_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_SEG = MAX_SEGMENTS,
  parameter int IDX_W   = 6,
  parameter int RAMP    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] round_len,
  input  logic [1:0]       colour_in,
  input  logic             pulse,
  output logic [IDX_W-1:0] seg_idx,
  output logic             load_speed,
  output logic [2:0]       speed,
  output logic [3:0]       led_o,
  output logic             busy,
  output logic             done
);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] seg_q, seg_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [2:0]       speed_q, speed_d;

  logic [IDX_W-1:0] len_clamp;
  logic [2:0]       lut_speed;
  logic             last_seg;

  seq_speed_lut #(
    .IDX_W(IDX_W),
    .RAMP (RAMP)
  ) u_lut (
    .round_len(round_len),
    .speed    (lut_speed)
  );

  assign len_clamp = (round_len > IDX_W'(MAX_SEG)) ?
                     IDX_W'(MAX_SEG) : round_len;

  assign last_seg = (seg_q == len_q - IDX_W'(1));

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    len_d   = len_q;
    speed_d = speed_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len_clamp;
          speed_d = lut_speed;
          seg_d   = '0;
          state_d = (len_clamp == '0) ? DONE : LOAD;
        end
      end
      // timer is reloading; pulse is not trusted here
      LOAD: state_d = ON;
      ON: begin
        if (pulse) state_d = GAP;
      end
      GAP: begin
        if (pulse) begin
          if (last_seg) begin
            state_d = DONE;
          end else begin
            seg_d   = seg_q + IDX_W'(1);
            state_d = ON;
          end
        end
      end
      DONE: begin
        seg_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything except an idle start
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      seg_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      seg_q   <= '0;
      len_q   <= '0;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      speed_q <= speed_d;
    end
  end

  assign seg_idx    = seg_q;
  assign speed      = speed_q;
  assign load_speed = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) && !abort;
  assign led_o      = (state_q == ON) ?
                      onehot(colour_t'(colour_in)) : 4'b0;

endmodule

// File: tb/tb_flash_sequencer.sv
// Randomised bench for flash_sequencer against a trace-level model.
// Drives start/abort/pulse, compares LED trace, latency, speed, done.
module tb_flash_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [5:0] round_len;
  logic [1:0] colour_in;
  logic       pulse;
  logic [5:0] seg_idx;
  logic       load_speed;
  logic [2:0] speed;
  logic [3:0] led_o;
  logic       busy;
  logic       done;

  flash_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .round_len (round_len),
    .colour_in (colour_in),
    .pulse     (pulse),
    .seg_idx   (seg_idx),
    .load_speed(load_speed),
    .speed     (speed),
    .led_o     (led_o),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [64];
  assign colour_in = mem[seg_idx];

  int   per = 4;
  int   pcnt = 0;
  logic pulse_gen = 1'b0;
  logic pulse_force = 1'b0;
  assign pulse = pulse_gen | pulse_force;

  always @(negedge clk) begin
    pcnt = (pcnt + 1 >= per) ? 0 : pcnt + 1;
    pulse_gen = (pcnt == 0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int         cyc = 0;
  int         t0;
  logic [3:0] trace[$];
  logic [3:0] last_led;
  int         load_cnt, done_cnt, max_idx;
  int         load_cyc, lit_cyc, done_cyc;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (led_o !== last_led) begin
      trace.push_back(led_o);
      last_led = led_o;
      if (led_o != 0 && lit_cyc < 0) lit_cyc = cyc;
    end
    if (load_speed) begin
      load_cnt++;
      if (load_cyc < 0) load_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (int'(seg_idx) > max_idx) max_idx = int'(seg_idx);
  end

  task automatic clear_rec();
    trace.delete();
    last_led = led_o;
    load_cnt = 0;
    done_cnt = 0;
    max_idx  = 0;
    load_cyc = -1;
    lit_cyc  = -1;
    done_cyc = -1;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 64; i++)
      mem[i] = 2'($urandom_range(0, 3));
  endtask

  // launch one playback and wait for it to finish
  task automatic run_play(input int rl,
                          input bit with_abort,
                          input bit mid_start);
    bit ok;
    @(negedge clk);
    clear_rec();
    round_len = 6'(rl);
    start = 1'b1;
    abort = with_abort;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (mid_start && seg_idx == 6'd3 && led_o == 4'b0) begin
        start = 1'b1;
        round_len = 6'd40;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) chk("play_timeout", 0, 1);
  endtask

  // expected behaviour derived from the playback rules
  task automatic check_play(input int rl);
    int L;
    int sp;
    logic [3:0] exp_tr[$];
    L  = (rl > 33) ? 33 : rl;
    sp = (rl / 5 > 4) ? 4 : rl / 5;
    for (int i = 0; i < L; i++) begin
      exp_tr.push_back(4'b0001 << mem[i]);
      exp_tr.push_back(4'b0000);
    end
    chk("trace_len", trace.size(), exp_tr.size());
    if (trace.size() == exp_tr.size())
      for (int i = 0; i < exp_tr.size(); i++)
        chk($sformatf("led[%0d]", i),
            int'(trace[i]), int'(exp_tr[i]));
    chk("speed", int'(speed), sp);
    chk("done_cnt", done_cnt, 1);
    chk("load_cnt", load_cnt, (L > 0) ? 1 : 0);
    chk("max_idx", max_idx, (L > 0) ? L - 1 : 0);
    if (L > 0) begin
      chk("load_lat", load_cyc - t0, 1);
      chk("lit_lat", lit_cyc - t0, 2);
    end else begin
      chk("done_lat", done_cyc - t0, 1);
    end
    chk("idle_seg", int'(seg_idx), 0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_seg"}, int'(seg_idx), 0);
    chk({pfx, "_speed"}, int'(speed), 0);
    chk({pfx, "_load"}, int'(load_speed), 0);
    chk({pfx, "_led"}, int'(led_o), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_done"}, int'(done), 0);
  endtask

  task automatic wait_for(input bit want_seg5);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (led_o != 0 && (!want_seg5 || seg_idx == 6'd5)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    int lens[6];
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    round_len = '0;
    for (int i = 0; i < 64; i++) mem[i] = 2'd0;
    clear_rec();
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b1;

    // directed sequence 2,0,3
    per = 4;
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
    run_play(3, 1'b0, 1'b0);
    check_play(3);

    // empty round, clamp, and abort-vs-start in IDLE
    rand_mem();
    run_play(0, 1'b0, 1'b0);
    check_play(0);
    per = 2;
    rand_mem();
    run_play(40, 1'b0, 1'b0);
    check_play(40);
    per = 3;
    rand_mem();
    run_play(7, 1'b1, 1'b0);
    check_play(7);

    // randomised rounds
    lens = '{1, 33, 34, 63, 19, 25};
    for (int k = 0; k < 14; k++) begin
      int rl;
      rl = (k < 6) ? lens[k] : int'($urandom_range(0, 63));
      per = int'($urandom_range(2, 6));
      rand_mem();
      run_play(rl, 1'b0, 1'b0);
      check_play(rl);
    end

    // second start during GAP is ignored
    per = 3;
    rand_mem();
    run_play(10, 1'b0, 1'b1);
    check_play(10);

    // abort in ON at seg 5 with a coincident pulse
    per = 3;
    rand_mem();
    @(negedge clk);
    clear_rec();
    round_len = 6'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(1'b1);
    abort = 1'b1;
    pulse_force = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_led", int'(led_o), 0);
    chk("abort_seg", int'(seg_idx), 0);
    @(negedge clk);
    abort = 1'b0;
    pulse_force = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", int'(busy), 0);

    // asynchronous reset mid-ON, then a fresh round
    @(negedge clk);
    round_len = 6'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_zero("areset");
    @(negedge clk);
    reset = 1'b1;
    rand_mem();
    run_play(12, 1'b0, 1'b0);
    check_play(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
